// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elevator_pkg;

    localparam int unsigned NFLR  = 4;
    localparam int unsigned FLR_W = $clog2(NFLR);

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef logic [FLR_W-1:0] flr_t;

    // One-hot mask with only the bit for the given floor set.
    function automatic logic [NFLR-1:0] flr_onehot(input flr_t flr);
        flr_onehot      = '0;
        flr_onehot[flr] = 1'b1;
    endfunction

endpackage

// File: rtl/elevator_dir_select.sv
// SCAN direction selection: looks at the calls beyond the floor the car is
// about to report and decides which way it should head next.
module elevator_dir_select
    import elevator_pkg::*;
(
    input  logic [NFLR-1:0] Pending,
    input  flr_t            NextFlr,
    input  logic            Dir,
    output logic            ahead,
    output logic            behind,
    output logic            DirNext
);

    logic [NFLR-1:0] above_mask;
    logic [NFLR-1:0] below_mask;
    logic            calls_above;
    logic            calls_below;

    // Split outstanding calls into those strictly above and strictly below NextFlr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NFLR; i++) begin
            above_mask[i] = (i > int'(NextFlr));
            below_mask[i] = (i < int'(NextFlr));
        end
        calls_above = |(Pending & above_mask);
        calls_below = |(Pending & below_mask);
    end

    // Keep going while calls lie ahead, otherwise reverse; the building ends force a direction.
    always_comb begin
        ahead   = (Dir == DIR_UP) ? calls_above : calls_below;
        behind  = (Dir == DIR_UP) ? calls_below : calls_above;
        DirNext = Dir;
        if (!ahead && behind) begin
            DirNext = ~Dir;
        end
        if (NextFlr == flr_t'(NFLR - 1)) begin
            DirNext = DIR_DN;
        end else if ((NextFlr == '0) && calls_above) begin
            DirNext = DIR_UP;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Call scheduler for the single-car elevator: latches calls, tracks floor and
// direction, and tells the door/motor state machine whether to keep moving.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned HOME = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NFLR-1:0] CallBtn,
    input  logic            Arrive,
    input  logic            MotorEn,
    output logic            Moving,
    output logic            Dir,
    output flr_t            CurFlr,
    output logic [NFLR-1:0] Pending,
    output logic            DoorReq
);

    logic [NFLR-1:0] pending_q, pending_d;
    flr_t            cur_flr_q, cur_flr_d;
    logic            dir_q, dir_d;
    logic            door_req_q, door_req_d;

    flr_t next_flr;
    logic stop;
    logic absorb;
    logic ahead, behind, dir_next;

    // Floor the car reports after this edge; saturates at both ends of the shaft.
    always_comb begin
        next_flr = cur_flr_q;
        if (Arrive) begin
            if (dir_q == DIR_UP) begin
                if (cur_flr_q != flr_t'(NFLR - 1)) next_flr = cur_flr_q + flr_t'(1);
            end else begin
                if (cur_flr_q != '0) next_flr = cur_flr_q - flr_t'(1);
            end
        end
    end

    elevator_dir_select u_dir_select (
        .Pending (pending_q),
        .NextFlr (next_flr),
        .Dir     (dir_q),
        .ahead   (ahead),
        .behind  (behind),
        .DirNext (dir_next)
    );

    // Stop/Moving lookahead, call latching and direction update for the next edge.
    always_comb begin
        stop   = Arrive & pending_q[next_flr];
        absorb = ~MotorEn & ~Arrive & CallBtn[cur_flr_q];
        Moving = (|(pending_q & ~flr_onehot(next_flr))) & ~stop;

        // A clear wins over a simultaneous press: that passenger is being served.
        pending_d = pending_q | CallBtn;
        if (stop)   pending_d[next_flr]  = 1'b0;
        if (absorb) pending_d[cur_flr_q] = 1'b0;

        cur_flr_d  = next_flr;
        door_req_d = absorb;
        // Direction is only re-evaluated at a floor, never between floors.
        dir_d      = (~MotorEn | Arrive) ? dir_next : dir_q;
    end

    // State registers with synchronous reset; reset also discards all calls.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            pending_q  <= '0;
            cur_flr_q  <= flr_t'(HOME);
            dir_q      <= DIR_UP;
            door_req_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            cur_flr_q  <= cur_flr_d;
            dir_q      <= dir_d;
            door_req_q <= door_req_d;
        end
    end

    assign Pending = pending_q;
    assign CurFlr  = cur_flr_q;
    assign Dir     = dir_q;
    // The door request is suppressed whenever the motor is running.
    assign DoorReq = door_req_q & ~MotorEn;

    logic unused_ok;
    assign unused_ok = ahead ^ behind;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: a driver applies directed and
// random stimulus and pushes the reference model's expectation; a monitor
// pops and compares every cycle on the falling edge.
module tb_elevator_scheduler;
    import elevator_pkg::*;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NFLR-1:0] CallBtn;
    logic            Arrive;
    logic            MotorEn;
    logic            Moving;
    logic            Dir;
    flr_t            CurFlr;
    logic [NFLR-1:0] Pending;
    logic            DoorReq;

    elevator_scheduler #(.HOME(0)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CallBtn (CallBtn),
        .Arrive  (Arrive),
        .MotorEn (MotorEn),
        .Moving  (Moving),
        .Dir     (Dir),
        .CurFlr  (CurFlr),
        .Pending (Pending),
        .DoorReq (DoorReq)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       moving;
        logic       dir;
        logic [1:0] flr;
        logic [3:0] pend;
        logic       door;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state, expressed as plain floor numbers and a call set.
    int     m_flr;
    bit     m_dir;
    bit [3:0] m_pend;
    bit     m_door;
    bit     m_valid = 1'b0;

    task automatic step(input bit rst, input bit [3:0] btn, input bit arr, input bit men);
        int   nf;
        bit   stop;
        bit   mv;
        bit   up_calls;
        bit   dn_calls;
        bit   ahead;
        bit   behind;
        bit [3:0] np;
        exp_t e;
        @(posedge CLK);
        #1;
        RST     = rst;
        CallBtn = btn;
        Arrive  = arr;
        MotorEn = men;

        if (m_valid && !rst && arr && m_flr == NFLR - 1 && m_dir) begin
            checks++;
            $display("FAIL illegal_arrive: Arrive at top floor %0d while heading up", m_flr);
        end

        // Floor after this edge: one step in travel direction, clamped to the shaft.
        nf = m_flr;
        if (arr) nf = m_dir ? ((m_flr < NFLR - 1) ? m_flr + 1 : m_flr)
                            : ((m_flr > 0) ? m_flr - 1 : m_flr);
        stop = arr && m_pend[nf];
        mv = 1'b0;
        for (int f = 0; f < NFLR; f++) if (m_pend[f] && f != nf) mv = 1'b1;
        if (stop) mv = 1'b0;

        if (m_valid) begin
            e.moving = mv;
            e.dir    = m_dir;
            e.flr    = 2'(m_flr);
            e.pend   = m_pend;
            e.door   = m_door && !men;
            sb.push_back(e);
        end

        if (rst) begin
            m_flr = 0; m_dir = 1'b1; m_pend = '0; m_door = 1'b0; m_valid = 1'b1;
            return;
        end

        np = m_pend | btn;
        if (stop) np[nf] = 1'b0;
        m_door = 1'b0;
        if (!men && !arr && btn[m_flr]) begin
            np[m_flr] = 1'b0;
            m_door    = 1'b1;
        end

        if (!men || arr) begin
            up_calls = 1'b0;
            dn_calls = 1'b0;
            for (int f = 0; f < NFLR; f++) begin
                if (m_pend[f] && f > nf) up_calls = 1'b1;
                if (m_pend[f] && f < nf) dn_calls = 1'b1;
            end
            ahead  = m_dir ? up_calls : dn_calls;
            behind = m_dir ? dn_calls : up_calls;
            if (!ahead && behind) m_dir = !m_dir;
            if (nf == NFLR - 1) m_dir = 1'b0;
            else if (nf == 0 && up_calls) m_dir = 1'b1;
        end
        m_flr  = nf;
        m_pend = np;
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({Moving, Dir, CurFlr, Pending, DoorReq} === e) begin
                    passes++;
                end else begin
                    $display("FAIL cycle_outputs @%0t: got mov=%b dir=%b flr=%0d pend=%b door=%b exp mov=%b dir=%b flr=%0d pend=%b door=%b",
                             $time, Moving, Dir, CurFlr, Pending, DoorReq,
                             e.moving, e.dir, e.flr, e.pend, e.door);
                end
            end
        end
    end

    initial begin
        bit [3:0] btn;
        bit       arr;
        bit       men;
        bit       rst;
        RST = 1'b1; CallBtn = '0; Arrive = 1'b0; MotorEn = 1'b0;

        // Reset held two edges, then idle at floor 0.
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        repeat (2) step(0, 4'b0000, 0, 0);

        // Single call up to floor 3.
        step(0, 4'b1000, 0, 0);
        step(0, 4'b0000, 0, 1);
        repeat (3) begin
            step(0, 4'b0000, 1, 1);
            step(0, 4'b0000, 0, 1);
        end
        step(0, 4'b0000, 0, 0);

        // SCAN ordering: park at floor 1 heading up, then calls at 0 and 3.
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0010, 0, 0);
        step(0, 4'b0000, 1, 1);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b1001, 0, 0);
        step(0, 4'b0000, 0, 0);
        repeat (5) begin
            step(0, 4'b0000, 1, 1);
            step(0, 4'b0000, 0, 1);
        end
        step(0, 4'b0000, 0, 0);

        // Travel to floor 2, then press floor 2 while stopped.
        step(0, 4'b0100, 0, 0);
        repeat (2) step(0, 4'b0000, 1, 1);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0100, 0, 0);
        repeat (2) step(0, 4'b0000, 0, 0);

        // Press and stop on the same floor in the same cycle.
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0000, 1, 1);
        step(0, 4'b0100, 1, 1);
        step(0, 4'b0000, 0, 0);

        // Reset mid-travel discards calls.
        step(0, 4'b1001, 0, 0);
        step(0, 4'b0000, 1, 1);
        step(1, 4'b0000, 0, 1);
        step(0, 4'b0000, 0, 0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            btn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            arr = ($urandom_range(0, 2) == 0);
            men = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 149) == 0);
            if (m_flr == NFLR - 1 && m_dir) arr = 1'b0;
            step(rst, btn, arr, men);
        end

        repeat (3) @(negedge CLK);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Call scheduler for the single-car, 4-floor elevator. It latches floor call buttons, tracks the car's current floor and travel direction, and drives the Moving request into the door/motor state machine using a SCAN policy: continue in the current direction while calls lie ahead, otherwise reverse, otherwise idle. It consumes the state machine's clr (arrival) pulse and MotorEn, and sits between the button debouncers and the state machine.

Parameters:
NFLR, 4, number of floors (CurFlr width = clog2(NFLR)); the RTL must be correct for NFLR=4, and other values are not required.
HOME, 0, floor index the car reports after reset.

Ports:
CLK  in  1  system clock, 1 Hz domain shared with the state machine
RST  in  1  synchronous, active-high reset
CallBtn  in  NFLR  debounced call buttons, level or pulse; bit i = floor i
Arrive  in  1  state machine clr; high exactly one cycle when the car reaches the next floor
MotorEn  in  1  state machine MotorEn; high while the car is in a moving state
Moving  out  1  request to the state machine: somewhere else to go (combinational)
Dir  out  1  travel direction; 1 = up, 0 = down (registered)
CurFlr  out  2  current floor index (registered)
Pending  out  NFLR  latched outstanding calls; also drives the button lamps (registered)
DoorReq  out  1  one-cycle pulse: reopen the door for a call at the current floor while stopped

Behaviour:
- Reset (RST high at a CLK edge, taking priority over all else): Pending=0, CurFlr=HOME, Dir=1, DoorReq=0. Moving then evaluates to 0.
- Reset mid-travel discards all calls. Floor tracking resynchronises only through Arrive.
- NextFlr (combinational):
  - When Arrive=1: CurFlr+1 if Dir=1, else CurFlr-1. Saturate at floor NFLR-1 and at floor 0.
  - Otherwise: CurFlr.
- Edge with Arrive=1: CurFlr <= NextFlr.
- Stop (combinational): Arrive & Pending[NextFlr].
  - Moving=0 in that cycle even if other calls exist, so the state machine takes s_Arrived -> s_dOpen.
- Moving (combinational): |(Pending & ~onehot(NextFlr)) & ~Stop.
  - This is lookahead: the state machine samples Moving on the same edge that ends s_Arrived, so the value must already refer to the new floor.
- Pending update per edge:
  - Set bit i when CallBtn[i]=1.
  - Clear bit NextFlr when Stop=1.
  - Clear bit CurFlr when MotorEn=0, Arrive=0 and CallBtn[CurFlr]=1; DoorReq=1 on that edge's output. The call is absorbed and not latched.
  - A simultaneous set and clear on the same bit resolves to clear, because that passenger is being served.
- Dir update: evaluate only when MotorEn=0 or Arrive=1, never between floors. Use ahead = calls strictly beyond NextFlr in direction Dir, behind = calls strictly beyond NextFlr in the opposite direction.
  - ahead nonzero -> keep Dir.
  - ahead zero, behind nonzero -> invert Dir.
  - Both zero -> hold Dir.
  - Forced rules, overriding the above: at NextFlr=NFLR-1, Dir=0; at NextFlr=0 with calls above, Dir=1.
- Arrive while Dir would leave the building (top floor with Dir=1): CurFlr holds.
  - This is an illegal input; the bench must flag it, but the RTL must not wrap.
- Latency:
  - CallBtn to Pending: 1 edge.
  - Pending to Moving: combinational, 0 edges.
  - Arrive to CurFlr: 1 edge.
- DoorReq is never asserted while MotorEn=1.

Decomposition:
- Package elevator_pkg:
  - NFLR
  - DIR_UP=1'b1, DIR_DN=1'b0
  - floor index typedef (2-bit)
  - onehot-of-floor function
- Sub-module elevator_dir_select (combinational): inputs Pending, NextFlr, Dir; outputs ahead, behind, DirNext.
  - Isolates the SCAN mask logic so it can be verified exhaustively (4x16x2 cases).
- Top elevator_scheduler holds the registers, Stop/Moving logic and DoorReq.

Test Plan:
- Reset, idle at floor 0: hold RST 2 edges, release -> CurFlr=0, Dir=1, Pending=0000, Moving=0, DoorReq=0.
- Single call up: CallBtn=1000 for 1 edge -> Pending=1000, Moving=1. Pulse Arrive three times -> CurFlr 1, 2, 3. On the third Arrive, Moving=0 in that cycle; Pending=0000 after the edge; Dir=0.
- SCAN ordering: car at floor 1 with Dir=1; Pending=0001 and 1000 latched in the same edge -> the car goes up first. Arrive -> CurFlr=2, Moving=1. Arrive -> CurFlr=3, stop, Dir flips to 0. Three more Arrives -> stop at floor 0; each intermediate Arrive gives Moving=1.
- Call at current floor while idle: car at floor 2, MotorEn=0, CallBtn=0100 -> DoorReq=1 for exactly 1 cycle, Pending stays 0000, Moving=0.
- Simultaneous press and stop: Arrive reaching floor 2 with Pending[2]=1 and CallBtn=0100 in the same cycle -> Pending[2]=0 after the edge, Moving=0.
- Reset mid-travel: MotorEn=1, Pending=1001, assert RST -> Pending=0000, CurFlr=0, Dir=1, Moving=0 on the next edge.
